// File: rtl/centroid_div_scheduler_if.sv
// rtl/centroid_div_scheduler_if.sv - request/response bus to the shared iterative divider
//
// master: the scheduler (drives start pulse and operands, samples ready/quotient)
// slave : the divider    (samples start/operands, drives ready/quotient)
//   div_start     1-cycle pulse, operands valid with it and held until capture
//   div_dividend  WIDTH dividend
//   div_divisor   WIDTH divisor
//   div_ready     high when idle / result valid, low while computing
//   div_quotient  WIDTH quotient, valid when div_ready returns high

interface centroid_div_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_ready;
    logic [WIDTH-1:0] div_quotient;

    modport master (
        output div_start,
        output div_dividend,
        output div_divisor,
        input  div_ready,
        input  div_quotient
    );

    modport slave (
        input  div_start,
        input  div_dividend,
        input  div_divisor,
        output div_ready,
        output div_quotient
    );
endinterface

// File: rtl/centroid_div_scheduler.sv
// rtl/centroid_div_scheduler.sv - time-shares one divider across the 8 centroid divisions of a frame
//
// Computes sum_x/num and sum_y/num for 4 colour markers using a single external
// iterative divider. Operands are snapshotted when start is accepted, the 8 jobs
// run in order (x0,y0,x1,y1,...), and all averages are published together.
//
// Ports:
//   clk_i        system clock
//   reset_n_i    synchronous active-low reset
//   start_i      pulse; snapshot operands and begin a schedule (only honoured in IDLE)
//   sum_x_i      colour k x-sum at [k*WIDTH +: WIDTH]
//   sum_y_i      colour k y-sum, same packing
//   num_i        colour k pixel count, same packing
//   div_if       master side of the shared divider bus
//   avg_x_o      colour k x-average at [k*XW +: XW] (quotient truncated)
//   avg_y_o      colour k y-average at [k*YW +: YW] (quotient truncated)
//   valid_o      bit k = colour k had a nonzero count in the last completed schedule
//   busy_o       high from the cycle after start is accepted until done
//   done_o       one-cycle pulse when new results appear on avg_x_o/avg_y_o/valid_o

module centroid_div_scheduler #(
    parameter int WIDTH = 32,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [4*WIDTH-1:0]     sum_x_i,
    input  logic [4*WIDTH-1:0]     sum_y_i,
    input  logic [4*WIDTH-1:0]     num_i,
    centroid_div_scheduler_if.master div_if,
    output logic [4*XW-1:0]        avg_x_o,
    output logic [4*YW-1:0]        avg_y_o,
    output logic [3:0]             valid_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_ACK,
        S_WAIT,
        S_NEXT,
        S_PUBLISH
    } state_t;

    state_t           state_q;
    logic [2:0]       j_q;          // job index: colour = j[2:1], j[0] selects y
    logic             ack_cnt_q;    // cycles already spent in ACK without div_ready dropping

    // Operand snapshot taken at start
    logic [WIDTH-1:0] snap_x_q [4];
    logic [WIDTH-1:0] snap_y_q [4];
    logic [WIDTH-1:0] snap_n_q [4];

    // Results being built by the running schedule
    logic [XW-1:0]    shadow_x_q [4];
    logic [YW-1:0]    shadow_y_q [4];
    logic [3:0]       shadow_valid_q;

    // Published results
    logic [XW-1:0]    avg_x_q [4];
    logic [YW-1:0]    avg_y_q [4];
    logic [3:0]       valid_q;

    logic             div_start_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]       col;
    logic [WIDTH-1:0] cur_dividend;
    logic [WIDTH-1:0] cur_divisor;

    // Only the low XW bits of the quotient are ever kept; the rest is discarded
    logic             unused_quotient_bits;

    assign col          = j_q[2:1];
    assign cur_divisor  = snap_n_q[col];
    assign cur_dividend = j_q[0] ? snap_y_q[col] : snap_x_q[col];

    assign unused_quotient_bits = ^div_if.div_quotient[WIDTH-1:XW];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            // Any in-flight divider job is abandoned; CHECK waits for the
            // divider to go idle before issuing the next request.
            state_q        <= S_IDLE;
            j_q            <= '0;
            ack_cnt_q      <= 1'b0;
            div_start_q    <= 1'b0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            shadow_valid_q <= '0;
            valid_q        <= '0;
            for (int k = 0; k < 4; k++) begin
                snap_x_q[k]   <= '0;
                snap_y_q[k]   <= '0;
                snap_n_q[k]   <= '0;
                shadow_x_q[k] <= '0;
                shadow_y_q[k] <= '0;
                avg_x_q[k]    <= '0;
                avg_y_q[k]    <= '0;
            end
        end else begin
            div_start_q <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < 4; k++) begin
                            snap_x_q[k] <= sum_x_i[k*WIDTH +: WIDTH];
                            snap_y_q[k] <= sum_y_i[k*WIDTH +: WIDTH];
                            snap_n_q[k] <= num_i[k*WIDTH +: WIDTH];
                        end
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (cur_divisor == '0) begin
                        // Empty colour: result is 0 and the divider is skipped
                        if (j_q[0]) begin
                            shadow_y_q[col] <= '0;
                        end else begin
                            shadow_x_q[col] <= '0;
                        end
                        shadow_valid_q[col] <= 1'b0;
                        state_q             <= S_NEXT;
                    end else if (div_if.div_ready) begin
                        // Holding here while div_ready is low only happens when
                        // a job abandoned by reset is still running.
                        dividend_q  <= cur_dividend;
                        divisor_q   <= cur_divisor;
                        div_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    ack_cnt_q <= 1'b0;
                    state_q   <= S_ACK;
                end

                S_ACK: begin
                    // A divider that never drops ready is treated as zero-latency
                    if (!div_if.div_ready || ack_cnt_q) begin
                        state_q <= S_WAIT;
                    end else begin
                        ack_cnt_q <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (div_if.div_ready) begin
                        if (j_q[0]) begin
                            shadow_y_q[col] <= div_if.div_quotient[YW-1:0];
                        end else begin
                            shadow_x_q[col] <= div_if.div_quotient[XW-1:0];
                        end
                        shadow_valid_q[col] <= 1'b1;
                        state_q             <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (j_q == 3'd7) begin
                        state_q <= S_PUBLISH;
                    end else begin
                        j_q     <= j_q + 3'd1;
                        state_q <= S_CHECK;
                    end
                end

                S_PUBLISH: begin
                    for (int k = 0; k < 4; k++) begin
                        avg_x_q[k] <= shadow_x_q[k];
                        avg_y_q[k] <= shadow_y_q[k];
                    end
                    valid_q <= shadow_valid_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div_if.div_start    = div_start_q;
    assign div_if.div_dividend = dividend_q;
    assign div_if.div_divisor  = divisor_q;

    for (genvar k = 0; k < 4; k++) begin : g_pack
        assign avg_x_o[k*XW +: XW] = avg_x_q[k];
        assign avg_y_o[k*YW +: YW] = avg_y_q[k];
    end

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// tb/tb_centroid_div_scheduler.sv - self-checking bench for centroid_div_scheduler

module tb_centroid_div_scheduler;

    localparam int WIDTH = 32;
    localparam int XW    = 10;
    localparam int YW    = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 start;
    logic [4*WIDTH-1:0]   sum_x;
    logic [4*WIDTH-1:0]   sum_y;
    logic [4*WIDTH-1:0]   num;
    logic [4*XW-1:0]      avg_x;
    logic [4*YW-1:0]      avg_y;
    logic [3:0]           valid;
    logic                 busy;
    logic                 done;

    centroid_div_scheduler_if #(.WIDTH(WIDTH)) div_bus ();

    centroid_div_scheduler #(.WIDTH(WIDTH), .XW(XW), .YW(YW)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .start_i   (start),
        .sum_x_i   (sum_x),
        .sum_y_i   (sum_y),
        .num_i     (num),
        .div_if    (div_bus),
        .avg_x_o   (avg_x),
        .avg_y_o   (avg_y),
        .valid_o   (valid),
        .busy_o    (busy),
        .done_o    (done)
    );

    // Divider model: ready low for div_lat cycles after a start pulse
    int               div_lat = 0;
    int               div_cnt = 0;
    logic [WIDTH-1:0] div_q   = '0;

    always @(posedge clk) begin
        if (div_bus.div_start === 1'b1) begin
            div_cnt <= div_lat;
            div_q   <= (div_bus.div_divisor != 0) ? div_bus.div_dividend / div_bus.div_divisor : '1;
        end else if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    assign div_bus.div_ready    = (div_cnt == 0);
    assign div_bus.div_quotient = div_q;

    int pulse_total = 0;
    int start_viol  = 0;

    always @(posedge clk) begin
        if (div_bus.div_start === 1'b1) begin
            pulse_total <= pulse_total + 1;
            if (!div_bus.div_ready) start_viol <= start_viol + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Last published results, as the bench expects them to appear
    logic [4*XW-1:0] prev_ax = '0;
    logic [4*YW-1:0] prev_ay = '0;
    logic [3:0]      prev_v  = '0;

    // Reference: averages from plain division, schedule length from per-job costs
    function automatic void model(input logic [127:0] sx, input logic [127:0] sy,
                                  input logic [127:0] n, input int d,
                                  output logic [4*XW-1:0] ax, output logic [4*YW-1:0] ay,
                                  output logic [3:0] v, output int cyc, output int pulses);
        logic [31:0] qx, qy, nk;
        cyc    = 2;
        pulses = 0;
        ax     = '0;
        ay     = '0;
        v      = '0;
        for (int k = 0; k < 4; k++) begin
            nk = n[k*32 +: 32];
            if (nk == 0) begin
                cyc += 2 * 2;
            end else begin
                qx = sx[k*32 +: 32] / nk;
                qy = sy[k*32 +: 32] / nk;
                ax[k*XW +: XW] = qx[XW-1:0];
                ay[k*YW +: YW] = qy[YW-1:0];
                v[k]    = 1'b1;
                pulses += 2;
                cyc    += 2 * ((d == 0) ? 6 : d + 4);
            end
        end
    endfunction

    // extra_start: cycle (1 = cycle after acceptance) at which another start is
    // pulsed; -1 none, -2 the PUBLISH cycle.
    task automatic run_sched(input logic [127:0] sx, input logic [127:0] sy, input logic [127:0] n,
                             input logic [4*XW-1:0] eax, input logic [4*YW-1:0] eay,
                             input logic [3:0] ev, input int d, input bit chk_time,
                             input int extra_start, input string tag);
        int cyc, exp_cyc, exp_p, p0, xs;
        logic [4*XW-1:0] mx;
        logic [4*YW-1:0] my;
        logic [3:0]      mv;
        bit got;
        model(sx, sy, n, d, mx, my, mv, exp_cyc, exp_p);
        xs      = (extra_start == -2) ? exp_cyc - 1 : extra_start;
        div_lat = d;
        sum_x   = sx;
        sum_y   = sy;
        num     = n;
        start   = 1'b1;
        p0      = pulse_total;
        cyc     = 0;
        got     = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                sum_x = {$urandom, $urandom, $urandom, $urandom};
                sum_y = {$urandom, $urandom, $urandom, $urandom};
                num   = {$urandom, $urandom, $urandom, $urandom};
            end
            if (cyc == xs) begin
                start        = 1'b1;
                sum_x[31:0]  = sum_x[31:0] + 32'd12345;
            end else if (cyc == xs + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                check({tag, "_hold_avg_x"}, avg_x, prev_ax);
                check({tag, "_hold_avg_y"}, avg_y, prev_ay);
                check({tag, "_hold_valid"}, valid, prev_v);
                check({tag, "_busy"}, busy, 1'b1);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got, 1'b1);
        if (chk_time) check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_div_pulses"}, pulse_total - p0, exp_p);
        check({tag, "_avg_x"}, avg_x, eax);
        check({tag, "_avg_y"}, avg_y, eay);
        check({tag, "_valid"}, valid, ev);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        prev_ax = eax;
        prev_ay = eay;
        prev_v  = ev;
        @(negedge clk);
        check({tag, "_single_done"}, done, 1'b0);
        check({tag, "_idle_after"}, busy, 1'b0);
        check({tag, "_avg_x_after"}, avg_x, eax);
    endtask

    typedef struct {
        logic [127:0]    sx;
        logic [127:0]    sy;
        logic [127:0]    n;
        logic [4*XW-1:0] ax;
        logic [4*YW-1:0] ay;
        logic [3:0]      v;
        int              d;
        int              extra;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [127:0]    rsx, rsy, rn;
        logic [4*XW-1:0] rax;
        logic [4*YW-1:0] ray;
        logic [3:0]      rv;
        int              rd, rc, rp;

        // basic schedule
        tbl[0].sx = {32'd40, 32'd1000, 32'd6400, 32'd3200};
        tbl[0].sy = {32'd80, 32'd999, 32'd1600, 32'd2400};
        tbl[0].n  = {32'd4, 32'd1, 32'd16, 32'd32};
        tbl[0].ax = {10'd10, 10'd1000, 10'd400, 10'd100};
        tbl[0].ay = {9'd20, 9'd487, 9'd100, 9'd75};
        tbl[0].v  = 4'b1111;
        tbl[0].d  = 33;
        tbl[0].extra = -1;
        // zero count on colour 2, with an ignored mid-schedule start
        tbl[1].sx = {32'd40, 32'd1000, 32'd6400, 32'd3200};
        tbl[1].sy = {32'd80, 32'd999, 32'd1600, 32'd2400};
        tbl[1].n  = {32'd4, 32'd0, 32'd16, 32'd32};
        tbl[1].ax = {10'd10, 10'd0, 10'd400, 10'd100};
        tbl[1].ay = {9'd20, 9'd0, 9'd100, 9'd75};
        tbl[1].v  = 4'b1011;
        tbl[1].d  = 33;
        tbl[1].extra = 50;
        // truncation, zero-latency divider, start during PUBLISH ignored
        tbl[2].sx = {32'hFFFF_FFFF, 32'd5000, 32'd7, 32'd100};
        tbl[2].sy = {32'hFFFF_FFFF, 32'd5000, 32'd0, 32'd50};
        tbl[2].n  = {32'd1, 32'd7, 32'd8, 32'd3};
        tbl[2].ax = {10'd1023, 10'd714, 10'd0, 10'd33};
        tbl[2].ay = {9'd511, 9'd202, 9'd0, 9'd16};
        tbl[2].v  = 4'b1111;
        tbl[2].d  = 0;
        tbl[2].extra = -2;
        // every colour empty
        tbl[3].sx = {32'd11, 32'd22, 32'd33, 32'd44};
        tbl[3].sy = {32'd55, 32'd66, 32'd77, 32'd88};
        tbl[3].n  = '0;
        tbl[3].ax = '0;
        tbl[3].ay = '0;
        tbl[3].v  = 4'b0000;
        tbl[3].d  = 7;
        tbl[3].extra = -1;

        // Reset held with start asserted
        reset_n = 1'b0;
        start   = 1'b1;
        sum_x   = tbl[0].sx;
        sum_y   = tbl[0].sy;
        num     = tbl[0].n;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_div_start", div_bus.div_start, 1'b0);
        check("rst_avg_x", avg_x, '0);
        check("rst_avg_y", avg_y, '0);
        check("rst_valid", valid, 4'b0);
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clk);

        // Table vectors, each started in the cycle after the previous done
        for (int i = 0; i < 4; i++) begin
            run_sched(tbl[i].sx, tbl[i].sy, tbl[i].n, tbl[i].ax, tbl[i].ay, tbl[i].v,
                      tbl[i].d, 1'b1, tbl[i].extra, $sformatf("vec%0d", i));
        end
        run_sched(tbl[0].sx, tbl[0].sy, tbl[0].n, tbl[0].ax, tbl[0].ay, tbl[0].v,
                  33, 1'b1, -1, "refill");

        // Reset during WAIT of job 3, then a schedule behind the stale divider job
        div_lat = 33;
        sum_x   = tbl[0].sx;
        sum_y   = tbl[0].sy;
        num     = tbl[0].n;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (119) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_avg_x", avg_x, '0);
        check("midrst_avg_y", avg_y, '0);
        check("midrst_valid", valid, 4'b0);
        reset_n = 1'b1;
        prev_ax = '0;
        prev_ay = '0;
        prev_v  = '0;
        run_sched(tbl[0].sx, tbl[0].sy, tbl[0].n, tbl[0].ax, tbl[0].ay, tbl[0].v,
                  33, 1'b0, -1, "post_rst");

        // Randomized schedules against the reference model
        for (int r = 0; r < 8; r++) begin
            rsx = {$urandom, $urandom, $urandom, $urandom};
            rsy = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                rn[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 70000));
            end
            rd = (r == 0) ? 0 : int'($urandom_range(0, 12));
            model(rsx, rsy, rn, rd, rax, ray, rv, rc, rp);
            run_sched(rsx, rsy, rn, rax, ray, rv, rd, 1'b1, -1, $sformatf("rnd%0d", r));
        end

        check("div_start_while_busy", start_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/centroid_div_scheduler.md
Name: centroid_div_scheduler

Overview:
Sequences one shared iterative unsigned divider across the 8 centroid divisions per frame. The divisions are sum_x/num and sum_y/num for each of 4 colour markers. This replaces 8 parallel divider instances with 1. It sits between the per-colour accumulators and the corner/edge-length stage. Inputs are snapshotted at start, divisions run in fixed order, and all averages are published atomically with a one-cycle done pulse.

Parameters:
WIDTH, 32, width of sums, counts and divider operands/quotient
XW, 10, width of each x-average output (quotient truncated to low XW bits)
YW, 9, width of each y-average output (quotient truncated to low YW bits)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  pulse; snapshot operands and begin a schedule
sum_x  in  4*WIDTH  colour k sum at [k*WIDTH +: WIDTH]
sum_y  in  4*WIDTH  colour k sum, same packing
num  in  4*WIDTH  colour k pixel count, same packing
div_start  out  1  one-cycle start pulse to shared divider
div_dividend  out  WIDTH  dividend to divider, held from ISSUE through capture
div_divisor  out  WIDTH  divisor to divider, held from ISSUE through capture
div_ready  in  1  divider idle/result-valid (high when idle, low while computing)
div_quotient  in  WIDTH  divider result, valid when div_ready returns high
avg_x  out  4*XW  colour k x-average at [k*XW +: XW]
avg_y  out  4*YW  colour k y-average at [k*YW +: YW]
valid  out  4  bit k = colour k had num!=0 in the last completed schedule
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when new results are published

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; div_start=0, busy=0, done=0.
  - avg_x, avg_y, valid, div_dividend and div_divisor all 0.
  - Job index cleared; shadow results cleared.
  - Reset wins over every other input, including mid-schedule. The divider is simply abandoned; the next schedule's ACK handles its state.
- Jobs run in index order j=0..7: j even = x of colour j/2, j odd = y of colour j/2. Divisor = num[j/2].
- States:
  - IDLE: on start=1, latch sum_x/sum_y/num into snapshot registers, j=0, busy=1, go to CHECK. When not in IDLE, start is ignored.
  - CHECK: if snapshot divisor==0, write shadow result 0, clear valid bit, go to NEXT (no divider access). Otherwise drive div_dividend/div_divisor and go to ISSUE.
  - ISSUE: div_start=1 for exactly this cycle; go to ACK.
  - ACK: wait for div_ready==0, then go to WAIT. If div_ready has not dropped after 2 cycles in ACK, treat it as a zero-latency divider and go to WAIT.
  - WAIT: on div_ready==1, capture div_quotient into the shadow slot for j (truncated to XW or YW), set valid bit for the colour, go to NEXT.
  - NEXT: if j==7 go to PUBLISH; else j=j+1, go to CHECK.
  - PUBLISH: copy shadow to avg_x/avg_y/valid in one cycle; done=1 for this cycle; busy=0; go to IDLE.
- Outputs avg_x/avg_y/valid change only in PUBLISH. They hold the previous results throughout a schedule.
- Cycle cost, with D = cycles div_ready is low:
  - Nonzero job: CHECK+ISSUE+ACK(1)+WAIT(D)+NEXT = D+4.
  - Zero job: 2 (CHECK+NEXT).
  - Total: start sampled at edge t, done high during cycle t+1+sum(job costs)+1.
- Quotient truncation: upper bits are discarded silently; no saturation.
- start coincident with PUBLISH is ignored (state not IDLE). start in the cycle after done is accepted.
- Changes on sum_x/sum_y/num after acceptance have no effect on the running schedule.
- div_start is never asserted outside ISSUE, and never asserted while div_ready==0.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> busy=0, done=0, div_start=0, avg_x=avg_y=valid=0.
- Basic schedule (divider model D=33):
  - Stimulus: colour0 sums 3200/2400 with num 32; colour1 6400/1600 with num 16; colour2 1000/999 with num 1; colour3 40/80 with num 4.
  - Required: exactly 8 div_start pulses; done 1+8*37+1 cycles after start.
  - Required averages: avg_x={10,1000 trunc to 10 bits=1000,400,100}; avg_y={20,999 trunc to 9 bits=487,100,75}; valid=4'b1111.
- Zero count: num[2]=0, others nonzero -> only 6 div_start pulses; avg_x/avg_y for colour 2 = 0; valid=4'b1011.
- Snapshot and ignore:
  - Change sum_x[0] and pulse start again mid-schedule -> results reflect original snapshot; single done pulse.
  - New start 1 cycle after done -> second schedule runs normally.
- Reset mid-schedule: drop reset_n during WAIT of job 3 -> next cycle busy=0, outputs 0. A following start completes correctly with the divider model still finishing its stale job.
- Output stability: previous results remain unchanged on avg_x/avg_y until the PUBLISH cycle of the next schedule; check every cycle.
